// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, grant codes, frame size.
// The CHK state and frame checksum helper exist only with UART_TX_ARB_CHECKSUM_EN.
package uart_pkg;

  localparam int UART_FRAME_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
`ifdef UART_TX_ARB_CHECKSUM_EN
    ST_WAIT = 3'd3,
    ST_CHK  = 3'd4
`else
    ST_WAIT = 3'd3
`endif
  } state_t;

  typedef enum logic {
    SRC_CMD = 1'b0,
    SRC_TLM = 1'b1
  } src_t;

`ifdef UART_TX_ARB_CHECKSUM_EN
  // XOR of the top nbytes bytes of a word, MSB byte first.
  function automatic logic [7:0] frame_xor(input logic [31:0] word, input int nbytes);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i < nbytes) begin
        acc = acc ^ word[8*(3-i) +: 8];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction
`endif

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, last_grant updated on i_upd_en.
// On a tie the source that did not win last time is granted.
module uart_rr_arb2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_req_cmd,
  input  logic i_req_tlm,
  input  logic i_upd_en,
  output logic o_gnt_valid,
  output src_t o_gnt_src,
  output src_t o_last_grant
);

  src_t r_last_grant;

  // Grant decision from the current requests and the previous winner.
  always_comb begin
    o_gnt_valid = i_req_cmd | i_req_tlm;
    o_gnt_src   = SRC_CMD;
    if (i_req_cmd && i_req_tlm) begin
      o_gnt_src = (r_last_grant == SRC_CMD) ? SRC_TLM : SRC_CMD;
    end else if (i_req_cmd) begin
      o_gnt_src = SRC_CMD;
    end else begin
      o_gnt_src = SRC_TLM;
    end
  end

  // Last-grant register; reset to TLM so CMD wins the first tie.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= SRC_TLM;
    end else if (i_upd_en) begin
      r_last_grant <= o_gnt_src;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign o_last_grant = r_last_grant;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between cmd and tlm word requesters.
// Define UART_TX_ARB_CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_BYTES  = UART_FRAME_BYTES,
  parameter int TX_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_req,
  input  logic [31:0] cmd_word,
  output logic        cmd_ack,
  input  logic        tlm_req,
  input  logic [31:0] tlm_word,
  output logic        tlm_ack,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        tx_done,
  output logic        busy,
  output logic        err_timeout
);

  localparam int               CNT_W     = $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TX_TIMEOUT);
  localparam logic [1:0]       BYTE_LAST = 2'(NUM_BYTES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_cmd_ack, r_tlm_ack, r_tx_start, r_busy, r_err_timeout;
  logic [7:0]        r_tx_byte;
  logic              w_cmd_ack_nxt, w_tlm_ack_nxt, w_tx_start_nxt, w_busy_nxt, w_err_nxt;
  logic [7:0]        w_tx_byte_nxt;
  // The first byte goes straight to tx_byte at capture, so only the rest is kept.
  logic [23:0]       r_shift;
  logic [1:0]        r_byte_cnt;
  logic [CNT_W-1:0]  r_tmo_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_load, w_shift, w_cnt_clr, w_arb_upd;
  logic              w_gnt_valid;
  src_t              w_gnt_src;
  src_t              w_last_grant;
  logic [31:0]       w_sel_word;
`ifdef UART_TX_ARB_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_chk_done;
  logic              w_chk_set;
`endif

  uart_rr_arb2 u_arb (
    .clk          (clk),
    .i_rst_n      (rst),
    .i_req_cmd    (cmd_req),
    .i_req_tlm    (tlm_req),
    .i_upd_en     (w_arb_upd),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_src    (w_gnt_src),
    .o_last_grant (w_last_grant)
  );

  // last_grant already holds the winner while in LOAD.
  assign w_sel_word = (w_last_grant == SRC_CMD) ? cmd_word : tlm_word;
  assign w_cnt_inc  = (r_tmo_cnt == CNT_MAX) ? CNT_MAX : (r_tmo_cnt + CNT_ONE);

  // Next-state and next-output decode; outputs are flopped from these values.
  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_ack_nxt  = 1'b0;
    w_tlm_ack_nxt  = 1'b0;
    w_tx_start_nxt = 1'b0;
    w_tx_byte_nxt  = 8'h00;
    w_busy_nxt     = r_busy;
    w_err_nxt      = 1'b0;
    w_arb_upd      = 1'b0;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    w_cnt_clr      = 1'b0;
`ifdef UART_TX_ARB_CHECKSUM_EN
    w_chk_set      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt   = ST_LOAD;
          w_arb_upd     = 1'b1;
          w_busy_nxt    = 1'b1;
          w_cmd_ack_nxt = (w_gnt_src == SRC_CMD);
          w_tlm_ack_nxt = (w_gnt_src == SRC_TLM);
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        w_load         = 1'b1;
        w_cnt_clr      = 1'b1;
        w_state_nxt    = ST_SEND;
        w_tx_start_nxt = 1'b1;
        w_tx_byte_nxt  = w_sel_word[31:24];
      end
      ST_SEND: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (r_byte_cnt == 2'd0) begin
`ifdef UART_TX_ARB_CHECKSUM_EN
            if (!r_chk_done) begin
              w_state_nxt    = ST_CHK;
              w_chk_set      = 1'b1;
              w_cnt_clr      = 1'b1;
              w_tx_start_nxt = 1'b1;
              w_tx_byte_nxt  = r_csum;
            end else begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
            end
`else
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
`endif
          end else begin
            w_shift        = 1'b1;
            w_cnt_clr      = 1'b1;
            w_state_nxt    = ST_SEND;
            w_tx_start_nxt = 1'b1;
            w_tx_byte_nxt  = r_shift[23:16];
          end
        end else if (w_cnt_inc >= CNT_LIMIT) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
`ifdef UART_TX_ARB_CHECKSUM_EN
      ST_CHK: begin
        w_state_nxt = ST_WAIT;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cmd_ack     <= 1'b0;
      r_tlm_ack     <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_byte     <= 8'h00;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ack     <= w_cmd_ack_nxt;
      r_tlm_ack     <= w_tlm_ack_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_tx_byte     <= w_tx_byte_nxt;
      r_busy        <= w_busy_nxt;
      r_err_timeout <= w_err_nxt;
    end
  end

  // Word shifter and remaining-byte counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift    <= 24'h000000;
      r_byte_cnt <= 2'd0;
    end else if (w_load) begin
      r_shift    <= w_sel_word[23:0];
      r_byte_cnt <= BYTE_LAST;
    end else if (w_shift) begin
      r_shift    <= {r_shift[15:0], 8'h00};
      r_byte_cnt <= r_byte_cnt - 2'd1;
    end else begin
      r_shift    <= r_shift;
      r_byte_cnt <= r_byte_cnt;
    end
  end

  // Cycles since the last tx_start; saturating so a stuck transmitter never wraps it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= w_cnt_inc;
    end
  end

`ifdef UART_TX_ARB_CHECKSUM_EN
  // Checksum of the captured word and whether it has gone out yet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum     <= 8'h00;
      r_chk_done <= 1'b0;
    end else if (w_load) begin
      r_csum     <= frame_xor(w_sel_word, NUM_BYTES);
      r_chk_done <= 1'b0;
    end else if (w_chk_set) begin
      r_csum     <= r_csum;
      r_chk_done <= 1'b1;
    end else begin
      r_csum     <= r_csum;
      r_chk_done <= r_chk_done;
    end
  end
`endif

  assign cmd_ack     = r_cmd_ack;
  assign tlm_ack     = r_tlm_ack;
  assign tx_start    = r_tx_start;
  assign tx_byte     = r_tx_byte;
  assign busy        = r_busy;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter; expected bytes are queued per frame
// and popped at each tx_start. Honours UART_TX_ARB_CHECKSUM_EN for frame length.
module tb_uart_tx_arbiter;

  localparam int TMO = 4095;
`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_req, tlm_req, tx_done;
  logic [31:0] cmd_word, tlm_word;
  logic        cmd_ack, tlm_ack, tx_start, busy, err_timeout;
  logic [7:0]  tx_byte;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(.NUM_BYTES(4), .TX_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_req(cmd_req), .cmd_word(cmd_word), .cmd_ack(cmd_ack),
    .tlm_req(tlm_req), .tlm_word(tlm_word), .tlm_ack(tlm_ack),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] outs();
    return {19'd0, cmd_ack, tlm_ack, tx_start, tx_byte, busy, err_timeout};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*(3-i) +: 8]);
`ifdef UART_TX_ARB_CHECKSUM_EN
    exp_q.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
  endtask

  task automatic wait_start(input string tag, output bit ok);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    ok = (tx_start === 1'b1);
    chk($sformatf("%s.start_wait", tag), {31'd0, ok}, 32'd1);
  endtask

  // One frame: ack/latency, every byte against the scoreboard, optional abort.
  // abort_mode 0: none, 1: withhold tx_done at byte abort_idx, 2: reset in its WAIT.
  task automatic frame(input string tag, input bit exp_tlm, input int delay,
                       input bit keep_req, input logic [31:0] next_word,
                       input int abort_mode, input int abort_idx);
    logic [7:0] exp_b;
    bit ok;
    push_word(exp_tlm ? tlm_word : cmd_word);
    chk($sformatf("%s.idle", tag), {31'd0, busy}, 32'd0);
    tick();
    chk($sformatf("%s.ack", tag), {30'd0, cmd_ack, tlm_ack}, exp_tlm ? 32'd1 : 32'd2);
    chk($sformatf("%s.busy", tag), {31'd0, busy}, 32'd1);
    tick();
    chk($sformatf("%s.ack_pulse", tag), {30'd0, cmd_ack, tlm_ack}, 32'd0);
    chk($sformatf("%s.start_lat", tag), {31'd0, tx_start}, 32'd1);
    if (exp_tlm) begin
      tlm_req = keep_req;
      tlm_word = next_word;
    end else begin
      cmd_req = keep_req;
      cmd_word = next_word;
    end
    for (int b = 0; b < FRAME_LEN; b++) begin
      wait_start(tag, ok);
      if (!ok) begin
        exp_q.delete();
        return;
      end
      exp_b = 8'hxx;
      if (exp_q.size() > 0) exp_b = exp_q.pop_front();
      else exp_b = 8'hxx;
      chk($sformatf("%s.byte%0d", tag, b), {24'd0, tx_byte}, {24'd0, exp_b});
      if (abort_mode == 1 && b == abort_idx) begin
        repeat (TMO - 1) tick();
        chk($sformatf("%s.tmo_early", tag), {30'd0, err_timeout, busy}, 32'd1);
        tick();
        chk($sformatf("%s.tmo_pulse", tag), {30'd0, err_timeout, busy}, 32'd2);
        tick();
        chk($sformatf("%s.tmo_end", tag), {31'd0, err_timeout}, 32'd0);
        exp_q.delete();
        return;
      end
      if (abort_mode == 2 && b == abort_idx) begin
        repeat (3) tick();
        chk($sformatf("%s.pre_rst", tag), {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1 chk($sformatf("%s.async_rst", tag), outs(), 32'd0);
        tick();
        rst = 1'b1;
        exp_q.delete();
        return;
      end
      tick();
      chk($sformatf("%s.strobe%0d", tag, b), {30'd0, tx_start, err_timeout}, 32'd0);
      repeat (delay - 1) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    chk($sformatf("%s.busy_end", tag), {30'd0, busy, tx_start}, 32'd0);
  endtask

  initial begin
    logic [1:0] seen;
    rst = 1'b0; cmd_req = 1'b0; tlm_req = 1'b0; tx_done = 1'b0;
    cmd_word = 32'h0; tlm_word = 32'h0;
    repeat (3) tick();
    chk("reset_outs", outs(), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_reset_outs", outs(), 32'd0);

    // Single cmd frame with a slow transmitter; also covers the checksum byte.
    cmd_word = 32'h12345678; cmd_req = 1'b1;
    frame("t1", 1'b0, 1860, 1'b0, 32'h0, 0, 0);

    // tx_done while idle must be ignored.
    tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
    chk("idle_done", outs(), 32'd0);

    // Simultaneous requests right after reset: cmd first, then tlm back-to-back.
    rst = 1'b0; tick(); rst = 1'b1; tick();
    cmd_word = 32'h0BADF00D; tlm_word = 32'hFFEEDDCC;
    cmd_req = 1'b1; tlm_req = 1'b1;
    frame("t2c", 1'b0, 3, 1'b0, 32'h0, 0, 0);
    frame("t2t", 1'b1, 3, 1'b0, 32'h0, 0, 0);

    // Both held high: the next tie goes to cmd, then strict alternation.
    cmd_word = 32'hC0DE0001; tlm_word = 32'h7E1E0001;
    cmd_req = 1'b1; tlm_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame($sformatf("t3_%0d", i), i[0], 2 + i, (i < 4), $urandom(), 0, 0);
    end

    // Withheld tx_done on the 2nd byte, then a normal frame.
    cmd_word = 32'hCAFE0001; cmd_req = 1'b1;
    frame("t4", 1'b0, 4, 1'b0, 32'h0, 1, 1);
    cmd_word = 32'h01020304; cmd_req = 1'b1;
    frame("t4n", 1'b0, 3, 1'b0, 32'h0, 0, 0);

    // tx_done on the last cycle before timeout still counts.
    tlm_word = 32'h89ABCDEF; tlm_req = 1'b1;
    frame("tlim", 1'b1, TMO - 1, 1'b0, 32'h0, 0, 0);

    // Reset during the WAIT of byte 3; nothing replays afterwards.
    cmd_word = 32'hDEADBEEF; cmd_req = 1'b1;
    frame("t5", 1'b0, 3, 1'b0, 32'h0, 2, 2);
    seen = 2'b00;
    repeat (5) begin
      tick();
      seen = seen | {tx_start, cmd_ack | tlm_ack};
    end
    chk("t5.no_replay", {30'd0, seen}, 32'd0);
    cmd_word = 32'h55AA33CC; tlm_word = 32'h0F1E2D3C;
    cmd_req = 1'b1; tlm_req = 1'b1;
    frame("t5c", 1'b0, 2, 1'b0, 32'h0, 0, 0);
    frame("t5t", 1'b1, 2, 1'b0, 32'h0, 0, 0);

    tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
